// File: rtl/round_timer_ctrl.sv
// round_timer_ctrl: get-ready pre-count, then a per-round BCD seconds countdown with pause, early clear, time-up and game-won handling
//   CLOCK_50, reset (async, active-high)        clock and reset
//   start_btn, pause_btn                        synchronised levels, acted on at their rising edges
//   abort, round_clear                          levels: return to IDLE / player finished the round
//   hundreds, tens, ones                        BCD timer digits
//   ready_count, round_num, state               pre-count seconds left, 1-based round, FSM encoding
//   game_active, time_up, game_won              registered status: level, one-cycle pulse, one-cycle pulse
module round_timer_ctrl #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int ROUND_SECONDS = 100,
  parameter int READY_SECONDS = 3,
  parameter int NUM_ROUNDS    = 3
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       abort,
  input  logic       round_clear,
  output logic [3:0] hundreds,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [1:0] ready_count,
  output logic [1:0] round_num,
  output logic [2:0] state,
  output logic       game_active,
  output logic       time_up,
  output logic       game_won
);
  typedef enum logic [2:0] {IDLE, READY, RUNNING, PAUSED, ROUND_END, TIME_UP, WON} state_t;
  localparam int DW = $clog2(TICKS_PER_SEC);
  localparam logic [DW-1:0] DIV_MAX = DW'(TICKS_PER_SEC - 1);
  localparam logic [3:0] H0 = 4'(ROUND_SECONDS / 100);
  localparam logic [3:0] T0 = 4'((ROUND_SECONDS / 10) % 10);
  localparam logic [3:0] O0 = 4'(ROUND_SECONDS % 10);
  localparam logic [1:0] RDY0 = 2'(READY_SECONDS);
  localparam logic [1:0] LAST_ROUND = 2'(NUM_ROUNDS);
  state_t        st;
  logic [DW-1:0] div;
  logic          start_prev, pause_prev;
  logic          start_rise, pause_rise, counting, tick, at_one, go_idle;
  logic [3:0]    h_dec, t_dec, o_dec;
  assign state      = st;
  assign start_rise = start_btn & ~start_prev;
  assign pause_rise = pause_btn & ~pause_prev;
  assign counting   = (st == READY) || (st == RUNNING);
  assign tick       = counting && (div == DIV_MAX);
  assign at_one     = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd1);
  // start in TIME_UP/WON begins a fresh game from IDLE, same as abort
  assign go_idle    = (abort && st != IDLE) || ((st == TIME_UP || st == WON) && start_rise);
  // BCD decrement: a zero digit wraps to 9 and borrows from the next digit up
  assign o_dec = (ones == 4'd0) ? 4'd9 : ones - 4'd1;
  assign t_dec = (ones != 4'd0) ? tens : (tens == 4'd0) ? 4'd9 : tens - 4'd1;
  assign h_dec = (ones == 4'd0 && tens == 4'd0) ? hundreds - 4'd1 : hundreds;
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      st          <= IDLE;
      div         <= '0;
      start_prev  <= 1'b0;
      pause_prev  <= 1'b0;
      hundreds    <= H0;
      tens        <= T0;
      ones        <= O0;
      ready_count <= 2'd0;
      round_num   <= 2'd1;
      game_active <= 1'b0;
      time_up     <= 1'b0;
      game_won    <= 1'b0;
    end else begin
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      time_up    <= 1'b0;
      game_won   <= 1'b0;
      // a tick wraps the divider, so READY->RUNNING enters with a cleared count
      if (counting) div <= tick ? '0 : div + DW'(1);
      if (go_idle) begin
        st          <= IDLE;
        div         <= '0;
        hundreds    <= H0;
        tens        <= T0;
        ones        <= O0;
        ready_count <= 2'd0;
        round_num   <= 2'd1;
        game_active <= 1'b0;
      end else
        case (st)
          IDLE: if (start_rise) begin
            st          <= READY;
            div         <= '0;
            ready_count <= RDY0;
            hundreds    <= H0;
            tens        <= T0;
            ones        <= O0;
          end
          READY: if (tick) begin
            ready_count <= ready_count - 2'd1;
            if (ready_count == 2'd1) begin
              st          <= RUNNING;
              game_active <= 1'b1;
            end
          end
          RUNNING:
            if (round_clear) begin
              st          <= ROUND_END;
              game_active <= 1'b0;
            end else if (tick && at_one) begin
              ones        <= 4'd0;
              st          <= TIME_UP;
              time_up     <= 1'b1;
              game_active <= 1'b0;
            end else begin
              if (tick) begin
                hundreds <= h_dec;
                tens     <= t_dec;
                ones     <= o_dec;
              end
              if (pause_rise) st <= PAUSED;
            end
          PAUSED: if (pause_rise) st <= RUNNING;
          ROUND_END:
            if (round_num == LAST_ROUND) begin
              st       <= WON;
              game_won <= 1'b1;
            end else begin
              st          <= READY;
              div         <= '0;
              round_num   <= round_num + 2'd1;
              ready_count <= RDY0;
              hundreds    <= H0;
              tens        <= T0;
              ones        <= O0;
            end
          default: ;
        endcase
    end
endmodule

// File: tb/tb_round_timer_ctrl.sv
// tb_round_timer_ctrl: directed and random stimulus scored against an integer-seconds reference model
module tb_round_timer_ctrl;
  localparam int TPS = 4, RS = 12, RDY = 3, NR = 2;
  logic       clk = 1'b0, reset = 1'b1;
  logic       start_btn = 1'b0, pause_btn = 1'b0, abort = 1'b0, round_clear = 1'b0;
  logic [3:0] hundreds, tens, ones;
  logic [1:0] ready_count, round_num;
  logic [2:0] state;
  logic       game_active, time_up, game_won;
  int n_cmp = 0, n_bad = 0;

  round_timer_ctrl #(.TICKS_PER_SEC(TPS), .ROUND_SECONDS(RS), .READY_SECONDS(RDY), .NUM_ROUNDS(NR)) dut (
    .CLOCK_50(clk), .reset(reset), .start_btn(start_btn), .pause_btn(pause_btn), .abort(abort),
    .round_clear(round_clear), .hundreds(hundreds), .tens(tens), .ones(ones), .ready_count(ready_count),
    .round_num(round_num), .state(state), .game_active(game_active), .time_up(time_up), .game_won(game_won));

  always #5 clk = ~clk;

  typedef struct {int st; int secs; int rdy; int rnd; bit tu; bit gw; bit ga;} exp_t;
  exp_t q[$];
  int m_st, m_secs, m_rdy, m_rnd, m_div;
  bit m_sp, m_pp;

  function automatic void check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_st = 0; m_secs = RS; m_rdy = 0; m_rnd = 1; m_div = 0; m_sp = 0; m_pp = 0;
  endfunction

  // one clock of the game rules; seconds held as a plain integer
  function automatic void model_step(bit s, bit p, bit a, bit rc);
    bit sr = s && !m_sp, pr = p && !m_pp;
    bit cnt = (m_st == 1 || m_st == 2);
    bit tk = cnt && (m_div == TPS - 1);
    int ns = m_st;
    exp_t e;
    m_sp = s; m_pp = p;
    if (cnt) m_div = tk ? 0 : m_div + 1;
    if ((a && m_st != 0) || ((m_st == 5 || m_st == 6) && sr)) begin
      ns = 0; m_secs = RS; m_rdy = 0; m_rnd = 1; m_div = 0;
    end else if (m_st == 0 && sr) begin
      ns = 1; m_rdy = RDY; m_secs = RS; m_div = 0;
    end else if (m_st == 1 && tk) begin
      m_rdy--;
      if (m_rdy == 0) ns = 2;
    end else if (m_st == 2) begin
      if (rc) ns = 4;
      else if (tk) begin
        m_secs--;
        ns = (m_secs == 0) ? 5 : pr ? 3 : 2;
      end else if (pr) ns = 3;
    end else if (m_st == 3 && pr) ns = 2;
    else if (m_st == 4) begin
      if (m_rnd == NR) ns = 6;
      else begin
        m_rnd++; m_secs = RS; m_rdy = RDY; m_div = 0; ns = 1;
      end
    end
    e.st = ns; e.secs = m_secs; e.rdy = m_rdy; e.rnd = m_rnd;
    e.tu = (ns == 5 && m_st != 5); e.gw = (ns == 6 && m_st != 6); e.ga = (ns == 2 || ns == 3);
    m_st = ns;
    q.push_back(e);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("sb_state", int'(state), e.st);
      check("sb_hundreds", int'(hundreds), e.secs / 100);
      check("sb_tens", int'(tens), (e.secs / 10) % 10);
      check("sb_ones", int'(ones), e.secs % 10);
      check("sb_ready_count", int'(ready_count), e.rdy);
      check("sb_round_num", int'(round_num), e.rnd);
      check("sb_time_up", int'(time_up), int'(e.tu));
      check("sb_game_won", int'(game_won), int'(e.gw));
      check("sb_game_active", int'(game_active), int'(e.ga));
    end
  end

  task automatic step(bit s, bit p, bit a, bit rc);
    @(negedge clk);
    start_btn = s; pause_btn = p; abort = a; round_clear = rc;
    model_step(s, p, a, rc);
    @(posedge clk);
    #2;
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start_btn = 0; pause_btn = 0; abort = 0; round_clear = 0; reset = 1;
    model_reset();
    @(negedge clk);
    reset = 0;
  endtask

  task automatic check_idle_values(string tag);
    check({tag, "_state"}, int'(state), 0);
    check({tag, "_digits"}, int'(hundreds) * 100 + int'(tens) * 10 + int'(ones), RS);
    check({tag, "_ready"}, int'(ready_count), 0);
    check({tag, "_round"}, int'(round_num), 1);
    check({tag, "_flags"}, int'({game_active, time_up, game_won}), 0);
  endtask

  initial begin
    int tu_cnt;
    model_reset();
    do_reset();
    #1;
    check_idle_values("reset");
    // pre-count then countdown to time-up
    step(1, 0, 0, 0);
    check("start_state", int'(state), 1);
    check("start_ready", int'(ready_count), 3);
    idle(4);  check("ready_2", int'(ready_count), 2);
    idle(4);  check("ready_1", int'(ready_count), 1);
    idle(3);  check("still_ready", int'(state), 1);
    idle(1);  check("running", int'(state), 2);
    check("running_digits", int'({hundreds, tens, ones}), 12'h012);
    tu_cnt = 0;
    for (int i = 1; i <= 48; i++) begin
      step(0, 0, 0, 0);
      if (time_up) tu_cnt++;
      if (i == 12) check("borrow_009", int'({hundreds, tens, ones}), 12'h009);
    end
    check("time_up_state", int'(state), 5);
    check("time_up_digits", int'({hundreds, tens, ones}), 12'h000);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      if (time_up) tu_cnt++;
    end
    check("time_up_pulses", tu_cnt, 1);
    check("hold_000", int'({hundreds, tens, ones}), 12'h000);
    // restart, pause mid-second, resume with the partial second preserved
    step(1, 0, 0, 0);
    check("restart_state", int'(state), 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(12);
    idle(8);
    check("at_010", int'({hundreds, tens, ones}), 12'h010);
    idle(1);
    step(0, 1, 0, 0);
    check("paused", int'(state), 3);
    idle(40);
    check("paused_hold", int'({hundreds, tens, ones}), 12'h010);
    step(0, 1, 0, 0);
    check("resumed", int'(state), 2);
    idle(1);
    check("resume_plus1", int'({hundreds, tens, ones}), 12'h010);
    idle(1);
    check("resume_plus2", int'({hundreds, tens, ones}), 12'h009);
    // early clears through both rounds to WON
    idle(8);
    check("at_007", int'({hundreds, tens, ones}), 12'h007);
    step(0, 0, 0, 1);
    check("round_end", int'(state), 4);
    check("round_end_digits", int'({hundreds, tens, ones}), 12'h007);
    step(0, 0, 0, 0);
    check("round2_ready", int'(state), 1);
    check("round2_num", int'(round_num), 2);
    check("round2_digits", int'({hundreds, tens, ones}), 12'h012);
    idle(12);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check("won_state", int'(state), 6);
    check("won_pulse", int'(game_won), 1);
    step(0, 0, 0, 0);
    check("won_pulse_end", int'(game_won), 0);
    check("won_round", int'(round_num), 2);
    step(1, 0, 0, 0);
    check("won_to_idle", int'(state), 0);
    check("won_round_reset", int'(round_num), 1);
    // clear coinciding with the final tick
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    idle(12);
    idle(44);
    check("at_001", int'({hundreds, tens, ones}), 12'h001);
    idle(3);
    step(0, 0, 0, 1);
    check("clear_beats_tick", int'(state), 4);
    check("clear_digits_001", int'({hundreds, tens, ones}), 12'h001);
    check("no_time_up", int'(time_up), 0);
    step(0, 0, 0, 0);
    check("no_time_up_after", int'(time_up), 0);
    // abort from PAUSED
    idle(12);
    step(0, 1, 0, 0);
    check("pause_before_abort", int'(state), 3);
    step(0, 0, 1, 0);
    check_idle_values("abort");
    // asynchronous reset between edges
    step(1, 0, 0, 0);
    idle(17);
    check("pre_reset_active", int'(game_active), 1);
    #1 reset = 1;
    #1 check_idle_values("async_reset");
    model_reset();
    @(negedge clk);
    reset = 0;
    // random stress
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 249) == 0, $urandom_range(0, 39) == 0);
    end
    repeat (3) @(posedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
